// File: rtl/spi_sclk_generator_if.sv
// SPI serial-clock generator bus.
// Groups the request/configuration inputs and the clock/strobe/handshake
// outputs of spi_sclk_generator.
//   master : SPI master control side (drives request and configuration).
//   slave  : clock generator side (drives SCLK, strobes, busy/done).
interface spi_sclk_generator_if #(
  parameter int unsigned DIV_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 6
);
  logic                 i_start;
  logic                 i_enable;
  logic [DIV_WIDTH-1:0] i_div;
  logic                 i_cpol;
  logic                 i_cpha;
  logic [CNT_WIDTH-1:0] i_num_bits;
  logic                 o_sclk;
  logic                 o_lead;
  logic                 o_trail;
  logic                 o_sample;
  logic                 o_shift;
  logic                 o_busy;
  logic                 o_done;

  modport master (
    output i_start, i_enable, i_div, i_cpol, i_cpha, i_num_bits,
    input  o_sclk, o_lead, o_trail, o_sample, o_shift, o_busy, o_done
  );

  modport slave (
    input  i_start, i_enable, i_div, i_cpol, i_cpha, i_num_bits,
    output o_sclk, o_lead, o_trail, o_sample, o_shift, o_busy, o_done
  );
endinterface

// File: rtl/spi_sclk_generator.sv
// Parametrised SPI serial-clock generator.
// Produces SCLK with programmable half-period (i_div+1 clocks), CPOL/CPHA
// modes, a burst of i_num_bits bits with busy/done handshake, an enable that
// freezes the clock mid-burst, and per-edge lead/trail/sample/shift strobes.
// Ports:
//   i_clk   : system clock, rising edge.
//   i_reset : synchronous active-high reset.
//   bus     : spi_sclk_generator_if slave modport
//             (i_start, i_enable, i_div, i_cpol, i_cpha, i_num_bits in;
//              o_sclk, o_lead, o_trail, o_sample, o_shift, o_busy, o_done out).
module spi_sclk_generator #(
  parameter int unsigned DIV_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  spi_sclk_generator_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_WIDTH:0]   edge_cnt_q, edge_cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic [CNT_WIDTH-1:0] num_bits_q, num_bits_d;
  logic                 sclk_q, sclk_d;
  logic                 lead_q, lead_d;
  logic                 trail_q, trail_d;
  logic                 sample_q, sample_d;
  logic                 shift_q, shift_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 tick;
  logic                 lead_edge;
  logic                 last_edge;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      div_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      num_bits_q <= '0;
      sclk_q     <= 1'b0;
      lead_q     <= 1'b0;
      trail_q    <= 1'b0;
      sample_q   <= 1'b0;
      shift_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      div_q      <= div_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      num_bits_q <= num_bits_d;
      sclk_q     <= sclk_d;
      lead_q     <= lead_d;
      trail_q    <= trail_d;
      sample_q   <= sample_d;
      shift_q    <= shift_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    div_d      = div_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    num_bits_d = num_bits_q;
    sclk_d     = sclk_q;
    lead_d     = 1'b0;
    trail_d    = 1'b0;
    sample_d   = 1'b0;
    shift_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    // Equality compare only, so an all-ones divisor never overflows.
    tick       = (div_cnt_q == div_q);
    // The edge about to happen moves SCLK away from idle when the current
    // level is the idle level.
    lead_edge  = (sclk_q == cpol_q);
    last_edge  = ((edge_cnt_q + 1'b1) == {num_bits_q, 1'b0});

    unique case (state_q)
      ST_IDLE: begin
        sclk_d = bus.i_cpol;
        busy_d = 1'b0;
        if (bus.i_start) begin
          if (bus.i_num_bits != '0) begin
            div_d      = bus.i_div;
            cpol_d     = bus.i_cpol;
            cpha_d     = bus.i_cpha;
            num_bits_d = bus.i_num_bits;
            div_cnt_d  = '0;
            edge_cnt_d = '0;
            busy_d     = 1'b1;
            state_d    = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (bus.i_enable) begin
          if (tick) begin
            div_cnt_d  = '0;
            sclk_d     = ~sclk_q;
            edge_cnt_d = edge_cnt_q + 1'b1;
            lead_d     = lead_edge;
            trail_d    = ~lead_edge;
            if (cpha_q) begin
              shift_d  = lead_edge;
              sample_d = ~lead_edge;
            end else begin
              sample_d = lead_edge;
              // The final trailing edge has no next bit to shift out.
              shift_d  = ~lead_edge & ~last_edge;
            end
            if (last_edge) begin
              state_d = ST_TAIL;
            end
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end
      end

      ST_TAIL: begin
        if (bus.i_enable) begin
          if (tick) begin
            div_cnt_d = '0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.o_sclk   = sclk_q;
  assign bus.o_lead   = lead_q;
  assign bus.o_trail  = trail_q;
  assign bus.o_sample = sample_q;
  assign bus.o_shift  = shift_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_done   = done_q;

endmodule

// File: tb/tb_spi_sclk_generator.sv
// Testbench for spi_sclk_generator: directed scenarios plus randomized bursts,
// each cycle of a burst compared against a reference that derives SCLK level
// and strobes from the number of enabled cycles elapsed since busy rose.
module tb_spi_sclk_generator;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_sclk_generator_if #(.DIV_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  spi_sclk_generator #(.DIV_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // {sclk, lead, trail, sample, shift, busy, done}
  function automatic logic [6:0] outs();
    return {bus.o_sclk, bus.o_lead, bus.o_trail, bus.o_sample,
            bus.o_shift, bus.o_busy, bus.o_done};
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // a   : enabled cycles counted since busy rose (excluding this one)
  // inc : the previous cycle was an enabled (counting) cycle
  function automatic logic [6:0] model(input int a, input bit inc, input int p,
                                       input int n, input bit cpol, input bit cpha);
    int  k;
    bit  edge_now, ld, tr, smp, sft, bsy, dn;
    k = a / p;
    if (k > 2*n) k = 2*n;
    edge_now = inc && (a > 0) && (a % p == 0) && (a / p <= 2*n);
    ld  = edge_now && (k % 2 == 1);
    tr  = edge_now && (k % 2 == 0);
    smp = cpha ? tr : ld;
    sft = cpha ? ld : (tr && k < 2*n);
    bsy = a < (2*n+1)*p;
    dn  = inc && (a == (2*n+1)*p);
    return {cpol ^ k[0], ld, tr, smp, sft, bsy, dn};
  endfunction

  // Called at a negedge of an IDLE cycle; returns at the negedge of the
  // o_done cycle with i_start low. dur = cycles from busy rise to DUT o_done.
  // en_mode: 0 enable held high, 1 random enable, 2 enable low for 5 cycles.
  task automatic run_burst(input int div, input bit cpol, input bit cpha,
                           input int n, input int en_mode,
                           output int dur, output int lows);
    int  a, p, limit;
    bit  inc, en, finished;
    logic [6:0] exp;
    p = div + 1;
    a = 0; inc = 0; dur = -1; lows = 0; finished = 0;
    limit = 4*(2*n+1)*p + 50;
    bus.i_start    = 1'b1;
    bus.i_div      = DW'(div);
    bus.i_cpol     = cpol;
    bus.i_cpha     = cpha;
    bus.i_num_bits = CW'(n);
    bus.i_enable   = 1'($urandom_range(0, 1));
    @(negedge clk);
    for (int c = 0; c < limit; c++) begin
      exp = model(a, inc, p, n, cpol, cpha);
      check("burst_cycle", outs(), exp);
      if (bus.o_done && dur < 0) dur = c;
      if (exp[0]) begin
        finished = 1;
        break;
      end
      // Mid-burst request/config changes must be ignored.
      bus.i_start    = ($urandom_range(0, 3) == 0);
      bus.i_div      = DW'($urandom);
      bus.i_cpol     = 1'($urandom);
      bus.i_cpha     = 1'($urandom);
      bus.i_num_bits = CW'($urandom);
      case (en_mode)
        1:       en = ($urandom_range(0, 3) != 0);
        2:       en = !(c >= 6 && c <= 10);
        default: en = 1'b1;
      endcase
      bus.i_enable = en;
      if (!en) lows++;
      if (en) a++;
      inc = en;
      @(negedge clk);
    end
    check_int("burst_finished", int'(finished), 1);
    bus.i_start  = 1'b0;
    bus.i_cpol   = cpol;
    bus.i_enable = 1'b1;
  endtask

  int d1, d2, l1, l2, edges;
  int rdiv, rn, rmode;
  bit rcpol, rcpha;

  initial begin
    rst            = 1'b1;
    bus.i_start    = 1'b0;
    bus.i_enable   = 1'b1;
    bus.i_div      = '0;
    bus.i_cpol     = 1'b1;
    bus.i_cpha     = 1'b0;
    bus.i_num_bits = '0;

    // Reset with CPOL=1 in IDLE: 0 during reset, idle level one cycle later.
    @(negedge clk);
    check("reset_state", outs(), 7'b0000000);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cpol1", outs(), 7'b1000000);
    bus.i_cpol = 1'b0;
    @(negedge clk);
    check("idle_cpol0", outs(), 7'b0000000);

    // Fastest clock, single bit.
    run_burst(0, 1'b0, 1'b0, 1, 0, d1, l1);
    check_int("dur_div0_n1", d1, 3);

    // Mode 3, div=3, 8 bits.
    run_burst(3, 1'b1, 1'b1, 8, 0, d1, l1);
    check_int("dur_div3_n8", d1, 68);
    @(negedge clk);
    check("idle_high_after_mode3", outs(), 7'b1000000);

    // Enable pause: exactly 5 extra cycles.
    run_burst(1, 1'b0, 1'b0, 4, 0, d1, l1);
    run_burst(1, 1'b0, 1'b0, 4, 2, d2, l2);
    check_int("dur_en_high", d1, 18);
    check_int("en_low_cycles", l2, 5);
    check_int("dur_en_pause_delta", d2 - d1, 5);

    // Reset during RUN on edge 3 of an 8-bit burst.
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_div      = DW'(1);
    bus.i_cpol     = 1'b0;
    bus.i_cpha     = 1'b0;
    bus.i_num_bits = CW'(8);
    edges = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      if (bus.o_lead || bus.o_trail) edges++;
      if (edges == 3) break;
    end
    check_int("rst_reached_edge3", edges, 3);
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort", outs(), 7'b0000000);
    rst = 1'b0;
    @(negedge clk);
    check("rst_no_done", outs(), 7'b0000000);
    run_burst(2, 1'b1, 1'b0, 8, 0, d1, l1);
    check_int("dur_after_rst", d1, 51);

    // N=0: done next cycle, no edges, busy stays low.
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_cpol     = 1'b0;
    bus.i_num_bits = '0;
    @(negedge clk);
    check("n0_done", outs(), 7'b0000001);
    bus.i_start = 1'b0;
    @(negedge clk);
    check("n0_after", outs(), 7'b0000000);

    // Back-to-back: second start in the o_done cycle of an N=2 burst.
    run_burst(1, 1'b0, 1'b1, 2, 0, d1, l1);
    check_int("dur_b2b_first", d1, 10);
    run_burst(0, 1'b1, 1'b0, 2, 0, d1, l1);
    check_int("dur_b2b_second", d1, 5);

    // Divisor and burst-length extremes.
    run_burst(255, 1'b0, 1'b1, 1, 0, d1, l1);
    check_int("dur_maxdiv", d1, 768);
    run_burst(0, 1'b1, 1'b0, 63, 1, d1, l1);
    check_int("dur_maxbits", d1, 127 + l1);

    // Randomized bursts, optionally chained back-to-back.
    for (int i = 0; i < 16; i++) begin
      rdiv  = $urandom_range(0, 5);
      rn    = $urandom_range(1, 6);
      rcpol = 1'($urandom);
      rcpha = 1'($urandom);
      rmode = $urandom_range(0, 1);
      run_burst(rdiv, rcpol, rcpha, rn, rmode, d1, l1);
      check_int("dur_random", d1, (2*rn+1)*(rdiv+1) + l1);
      if ($urandom_range(0, 1) == 1) begin
        bus.i_enable = 1'($urandom);
        @(negedge clk);
        check("random_idle", outs(), {rcpol, 6'b000000});
        bus.i_enable = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
